// File: rtl/dfi_rddata_packer_if.sv
// Stream bundle between the DFI read-data packer and its neighbours.
// The slave side is the packer, the master side is the PHY and the read-return consumer.
interface dfi_rddata_packer_if #(
    parameter int NPHASES = 8,
    parameter int DW      = 32,
    parameter int DEPTH   = 4
);
    logic [NPHASES*DW-1:0]        dfi_rddata_i;
    logic [NPHASES-1:0]           dfi_rddata_valid_i;
    logic                         clr_i;
    logic                         rd_valid_o;
    logic                         rd_ready_i;
    logic [NPHASES*DW-1:0]        rd_data_o;
    logic [$clog2(DEPTH+1)-1:0]   level_o;
    logic [$clog2(NPHASES)-1:0]   acc_cnt_o;
    logic                         overflow_o;

    modport master (
        output dfi_rddata_i, dfi_rddata_valid_i, clr_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, level_o, acc_cnt_o, overflow_o
    );

    modport slave (
        input  dfi_rddata_i, dfi_rddata_valid_i, clr_i, rd_ready_i,
        output rd_valid_o, rd_data_o, level_o, acc_cnt_o, overflow_o
    );
endinterface

// File: rtl/dfi_rddata_packer.sv
// Compacts valid DFI read phase-words into full beats and buffers them in a
// first-word-fall-through FIFO with a sticky overflow flag.
module dfi_rddata_packer #(
    parameter int NPHASES = 8,
    parameter int DW      = 32,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    dfi_rddata_packer_if.slave bus
);
    localparam int CW = $clog2(NPHASES);
    localparam int NW = $clog2(NPHASES + 1);
    localparam int SW = CW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = NPHASES * DW;

    logic [DW-1:0] r_acc [NPHASES];
    logic [CW-1:0] r_acc_cnt;
    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    logic [DW-1:0] w_cmp [NPHASES];
    logic [NW-1:0] w_n;
    logic [DW-1:0] w_comb [2*NPHASES];
    logic [DW-1:0] w_acc_nxt [NPHASES];
    logic [SW-1:0] w_sum;
    logic          w_complete;
    logic [CW-1:0] w_cnt_nxt;
    logic [BW-1:0] w_beat;
    logic          w_rd_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;

    // Stage 0: squeeze valid phase-words down to the low slots in phase order
    always_comb begin
        w_n = '0;
        for (int p = 0; p < NPHASES; p++) begin
            w_cmp[p] = '0;
        end
        for (int p = 0; p < NPHASES; p++) begin
            if (bus.dfi_rddata_valid_i[p]) begin
                w_cmp[w_n[CW-1:0]] = bus.dfi_rddata_i[p*DW +: DW];
                w_n = w_n + 1'b1;
            end
        end
    end

    // Held words first, then the freshly compacted words behind them
    always_comb begin
        for (int i = 0; i < NPHASES; i++) begin
            if (i < int'(r_acc_cnt)) begin
                w_comb[i] = r_acc[i];
            end else begin
                w_comb[i] = w_cmp[CW'(i - int'(r_acc_cnt))];
            end
        end
        for (int i = NPHASES; i < 2*NPHASES; i++) begin
            if (i - int'(r_acc_cnt) < NPHASES) begin
                w_comb[i] = w_cmp[CW'(i - int'(r_acc_cnt))];
            end else begin
                w_comb[i] = '0;
            end
        end
    end

    always_comb begin
        w_sum      = SW'(r_acc_cnt) + SW'(w_n);
        w_complete = (w_sum >= SW'(NPHASES));
        w_cnt_nxt  = w_complete ? CW'(w_sum - SW'(NPHASES)) : CW'(w_sum);
        w_beat     = '0;
        for (int j = 0; j < NPHASES; j++) begin
            w_beat[j*DW +: DW] = w_comb[j];
            w_acc_nxt[j]       = w_complete ? w_comb[NPHASES + j] : w_comb[j];
        end
    end

    // Pop frees a slot in the same cycle, so a full FIFO still takes a push then
    always_comb begin
        w_rd_valid = (r_level != '0);
        w_full     = (r_level == LW'(DEPTH));
        w_pop      = w_rd_valid && bus.rd_ready_i;
        w_push_ok  = w_complete && (!w_full || w_pop);
        w_drop     = w_complete && w_full && !w_pop;
    end

    // Stage 1: accumulator, FIFO control and overflow state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NPHASES; j++) begin
                r_acc[j] <= '0;
            end
            r_acc_cnt  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr_i) begin
            for (int j = 0; j < NPHASES; j++) begin
                r_acc[j] <= '0;
            end
            r_acc_cnt  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int j = 0; j < NPHASES; j++) begin
                r_acc[j] <= w_acc_nxt[j];
            end
            r_acc_cnt <= w_cnt_nxt;
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Beat storage carries no reset; the empty mux hides stale contents
    always_ff @(posedge clk) begin
        if (w_push_ok && !bus.clr_i && !rst) begin
            r_mem[r_wptr] <= w_beat;
        end
    end

    assign bus.rd_valid_o = w_rd_valid;
    assign bus.rd_data_o  = w_rd_valid ? r_mem[r_rptr] : '0;
    assign bus.level_o    = r_level;
    assign bus.acc_cnt_o  = r_acc_cnt;
    assign bus.overflow_o = r_overflow;
endmodule

// File: tb/tb_dfi_rddata_packer.sv
// Directed bench for dfi_rddata_packer: vector table plus flush/reset sequences.
module tb_dfi_rddata_packer;
    localparam int NP = 8;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    dfi_rddata_packer_if #(.NPHASES(NP), .DW(DW), .DEPTH(DP)) bus ();

    dfi_rddata_packer #(.NPHASES(NP), .DW(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, got no finish, want finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0]   mask;
        logic [31:0]  base;
        logic         rdy;
        logic         clr;
        logic         e_vld;
        logic [255:0] e_data;
        logic [2:0]   e_lvl;
        logic [2:0]   e_acc;
        logic         e_ovf;
    } vec_t;

    vec_t vt[$];

    function automatic logic [255:0] beat8(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    function automatic logic [255:0] burst(input logic [31:0] base);
        return beat8(base, base + 1, base + 2, base + 3, base + 4, base + 5, base + 6, base + 7);
    endfunction

    function automatic vec_t mk(input logic [7:0] mask, input logic [31:0] base,
                                input logic rdy, input logic clr, input logic e_vld,
                                input logic [255:0] e_data, input logic [2:0] e_lvl,
                                input logic [2:0] e_acc, input logic e_ovf);
        vec_t v;
        v.mask = mask; v.base = base; v.rdy = rdy; v.clr = clr;
        v.e_vld = e_vld; v.e_data = e_data; v.e_lvl = e_lvl; v.e_acc = e_acc; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    endtask

    task automatic check_all(input string tag, input int idx, input logic vld, input logic [255:0] dat,
                             input logic [2:0] lvl, input logic [2:0] acc, input logic ovf);
        chk({tag, ".rd_valid"}, idx, 256'(bus.rd_valid_o), 256'(vld));
        chk({tag, ".rd_data"},  idx, bus.rd_data_o, dat);
        chk({tag, ".level"},    idx, 256'(bus.level_o), 256'(lvl));
        chk({tag, ".acc_cnt"},  idx, 256'(bus.acc_cnt_o), 256'(acc));
        chk({tag, ".overflow"}, idx, 256'(bus.overflow_o), 256'(ovf));
    endtask

    // drive on negedge side, let posedge act, sample on following negedge
    task automatic step(input logic [7:0] mask, input logic [31:0] base, input logic rdy, input logic clr);
        bus.dfi_rddata_valid_i = mask;
        bus.dfi_rddata_i       = burst(base);
        bus.rd_ready_i         = rdy;
        bus.clr_i              = clr;
        @(posedge clk);
        @(negedge clk);
        bus.dfi_rddata_valid_i = '0;
        bus.rd_ready_i         = 1'b0;
        bus.clr_i              = 1'b0;
    endtask

    // overflow set, two beats held, three words in the accumulator
    task automatic build_dirty_state();
        for (int k = 1; k <= 5; k++) step(8'hFF, 32'h0100_0000 * k, 1'b0, 1'b0);
        step(8'h00, 32'h0, 1'b1, 1'b0);
        step(8'h00, 32'h0, 1'b1, 1'b0);
        step(8'h07, 32'hD000_0000, 1'b0, 1'b0);
    endtask

    logic [255:0] bA, bB, bS, b1, b2, b3, b4, b5, bF;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.dfi_rddata_i       = '0;
        bus.dfi_rddata_valid_i = '0;
        bus.clr_i              = 1'b0;
        bus.rd_ready_i         = 1'b0;

        bA = beat8(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                   32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);
        bB = beat8(32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007,
                   32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
        bS = beat8(32'd0, 32'd2, 32'd5, 32'd7, 32'd0, 32'd2, 32'd5, 32'd7);
        bF = beat8(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                   32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007);
        b1 = burst(32'h0100_0000);
        b2 = burst(32'h0200_0000);
        b3 = burst(32'h0300_0000);
        b4 = burst(32'h0400_0000);
        b5 = burst(32'h0500_0000);

        // full burst, pushed into an empty FIFO with ready high
        vt.push_back(mk(8'hFF, 32'h1000_0000, 1, 0, 1, bF, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 0, '0, 3'd0, 3'd0, 0));
        // split burst
        vt.push_back(mk(8'h0F, 32'hA000_0000, 0, 0, 0, '0, 3'd0, 3'd4, 0));
        vt.push_back(mk(8'hFF, 32'hB000_0000, 0, 0, 1, bA, 3'd1, 3'd4, 0));
        vt.push_back(mk(8'h0F, 32'hC000_0000, 0, 0, 1, bA, 3'd2, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, bB, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 0, '0, 3'd0, 3'd0, 0));
        // sparse mask, data = phase index
        vt.push_back(mk(8'hA5, 32'h0, 0, 0, 0, '0, 3'd0, 3'd4, 0));
        vt.push_back(mk(8'hA5, 32'h0, 0, 0, 1, bS, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'hA5, 32'h0, 0, 0, 1, bS, 3'd1, 3'd4, 0));
        vt.push_back(mk(8'hA5, 32'h0, 0, 0, 1, bS, 3'd2, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, bS, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 0, '0, 3'd0, 3'd0, 0));
        // overflow with consumer stalled
        vt.push_back(mk(8'hFF, 32'h0100_0000, 0, 0, 1, b1, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0200_0000, 0, 0, 1, b1, 3'd2, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0300_0000, 0, 0, 1, b1, 3'd3, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0400_0000, 0, 0, 1, b1, 3'd4, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0500_0000, 0, 0, 1, b1, 3'd4, 3'd0, 1));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, b2, 3'd3, 3'd0, 1));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, b3, 3'd2, 3'd0, 1));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, b4, 3'd1, 3'd0, 1));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 0, '0, 3'd0, 3'd0, 1));
        // clear discards the incoming burst and the sticky flag
        vt.push_back(mk(8'hFF, 32'h0900_0000, 1, 1, 0, '0, 3'd0, 3'd0, 0));
        // full FIFO with a same-cycle pop accepts the push
        vt.push_back(mk(8'hFF, 32'h0100_0000, 0, 0, 1, b1, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0200_0000, 0, 0, 1, b1, 3'd2, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0300_0000, 0, 0, 1, b1, 3'd3, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0400_0000, 0, 0, 1, b1, 3'd4, 3'd0, 0));
        vt.push_back(mk(8'hFF, 32'h0500_0000, 1, 0, 1, b2, 3'd4, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, b3, 3'd3, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, b4, 3'd2, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 1, b5, 3'd1, 3'd0, 0));
        vt.push_back(mk(8'h00, 32'h0, 1, 0, 0, '0, 3'd0, 3'd0, 0));

        @(negedge clk);
        check_all("reset_hold", 0, 0, '0, 3'd0, 3'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("post_reset", 0, 0, '0, 3'd0, 3'd0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].mask, vt[i].base, vt[i].rdy, vt[i].clr);
            check_all("vec", i, vt[i].e_vld, vt[i].e_data, vt[i].e_lvl, vt[i].e_acc, vt[i].e_ovf);
        end

        // flush from a dirty state, with ready high that must be ignored
        build_dirty_state();
        check_all("dirty_a", 0, 1, b3, 3'd2, 3'd3, 1);
        step(8'hFF, 32'h0E00_0000, 1'b1, 1'b1);
        check_all("flush", 0, 0, '0, 3'd0, 3'd0, 0);
        step(8'h00, 32'h0, 1'b0, 1'b0);
        check_all("flush_idle", 0, 0, '0, 3'd0, 3'd0, 0);

        // asynchronous reset in the middle of a cycle
        build_dirty_state();
        check_all("dirty_b", 0, 1, b3, 3'd2, 3'd3, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, '0, 3'd0, 3'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("rst_release", 0, 0, '0, 3'd0, 3'd0, 0);
        step(8'hFF, 32'h1000_0000, 1'b0, 1'b0);
        check_all("after_rst", 0, 1, bF, 3'd1, 3'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
